cpu: RTL and testbench
======================

# cpu

Multi-cycle 16-bit processor core: an instruction register, a decoder, a control FSM and a datapath with an 8×16 register file, barrel-less shifter, ALU and status flags. It executes one instruction per start request, presented on `in` by an external driver, and signals idle via `w`. It is the top of the lab processor; memory and program counter are out of scope.

## Interface
- No parameters.
- `clk`  in  1  single rising-edge clock.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `s`  in  1  start; sampled only in Wait state.
- `load`  in  1  instruction-register load enable.
- `in`  in  16  instruction word.
- `out`  out  16  datapath result register C.
- `N`  out  1  status negative.
- `V`  out  1  status signed overflow.
- `Z`  out  1  status zero.
- `w`  out  1  high exactly while FSM is in Wait.

## Operation
- IR: on any clock edge with `load`=1, IR←`in`, independent of FSM state.
- Fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0], im8=IR[7:0], sximm8 = sign-extend(im8) to 16 bits.
- Instructions:
  - 110/10 MOV Rn,#im8: Rn←sximm8.
  - 110/00 MOV Rd,Rm{,sh}: Rd←sh(Rm).
  - 101/00 ADD Rd,Rn,Rm{,sh}: Rd←Rn+sh(Rm).
  - 101/01 CMP Rn,Rm{,sh}: compute Rn−sh(Rm), update N,V,Z only; no register write.
  - 101/10 AND Rd,Rn,Rm{,sh}: Rd←Rn & sh(Rm).
  - 101/11 MVN Rd,Rm{,sh}: Rd←~sh(Rm).
  - Any other opcode/op: no-op, return to Wait.
- Shifter on B operand: sh=00 none; 01 LSL 1 (LSB←0); 10 LSR 1 (MSB←0); 11 ASR 1 (MSB kept).
- Arithmetic: 16-bit modulo; Z=(result==0), N=result[15], V=signed overflow of the add/sub actually performed. Status register loads only in CMP's compute step.
- FSM states: Wait, Decode, WriteImm, GetA, GetB, Compute, WriteReg.
  - Wait: `s`=1 → Decode, else stay.
  - Decode: MOV imm → WriteImm; MOV reg, MVN → GetB; ADD, CMP, AND → GetA; illegal → Wait.
  - WriteImm: write sximm8 to Rn → Wait.
  - GetA: A←R[Rn] → GetB.
  - GetB: B←R[Rm] → Compute.
  - Compute: C←ALU(Ain, sh(B)); Ain forced to 0 for MOV reg/MVN; CMP also loads status and → Wait; others → WriteReg.
  - WriteReg: R[Rd]←C → Wait.
- Reset: FSM←Wait; IR, A, B, C, status and R0–R7 cleared to 0. So `out`=0, N=V=Z=0, `w`=1 after the reset edge.
- Reset mid-instruction aborts it; no pending write occurs on the reset edge.

## Timing
- Edge counts are from the edge that samples `s`=1 in Wait.
- `load`=1 and `s`=1 on the same edge: IR captures the new word on that edge, and Decode uses it.
- `w` falls one edge after start; it rises when Wait is re-entered:
  - MOV imm: 3 edges.
  - CMP: 5 edges.
  - MOV reg, MVN: 5 edges.
  - ADD, AND: 6 edges.
- Register-file write is visible on the edge leaving WriteImm or WriteReg.
- `out` changes only on the Compute edge.
- If `s` is still high when Wait is re-entered, the same IR re-executes (driver responsibility).

## Structure
- Shared package holds:
  - opcode/op encodings;
  - shift codes;
  - FSM state enum;
  - ALU op codes (add, sub, and, not).
- Sub-modules: datapath instance `DP`, containing register-file instance `REGFILE`.
  - `REGFILE` exposes 16-bit registers named `R0`–`R7`.
  - Benches read them hierarchically as `DUT.DP.REGFILE.Rx`.
- Control FSM and IR live in `cpu`.

## Test plan
- Reset 2 cycles → `w`=1, `out`=0, all R=0; MOV R0,#7 (0xD007) → R0=7, `w` rises 3 edges after start.
- MOV R1,#−2 (0xD1FE) → R1=0xFFFE (sign extension); then MOV R2,R1,LSR (0xC051) → R2=0x7FFF.
- MOV R1,#2; MOV R3,#3; ADD R4,R1,R3,LSL (0xA18B) → R4=8, `out`=8, flags unchanged.
- MOV R5,#3; CMP R5,R5 (0xAD05) → Z=1, N=0, V=0, no register changes. Then MOV R6,#0x80, MOV R6,R6,LSL repeated to 0x8000, MOV R7,#1, CMP R6,R7 → V=1, N=0.
- AND R0,R1,R3 with R1=6,R3=3 → R0=2; MVN R2,R3 → R2=0xFFFC; ASR of 0x8000 → 0xC000.
- Assert reset during GetB of an ADD → Wait next edge, destination unchanged (0), `w`=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the lab processor core.
// Holds instruction encodings, shifter codes, ALU operation codes and the
// control FSM state enum. No ports; imported by cpu, cpu_datapath and
// cpu_regfile.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int REG_SEL_W = 3;

  // Top-level opcode field, IR[15:13]
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // Secondary op field, IR[12:11]
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_NOT = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_COMPUTE   = 3'd5,
    S_WRITE_REG = 3'd6
  } state_e;

  // Sign-extend the 8-bit immediate to a full data word.
  function automatic logic [DATA_W-1:0] sx_imm8(input logic [7:0] im8);
    return {{(DATA_W-8){im8[7]}}, im8};
  endfunction

endpackage

// File: rtl/cpu_datapath.sv
// Datapath: register file, A/B operand registers, shifter on B, ALU,
// result register C and N/V/Z status register.
// Ports:
//   clk, reset          - clock, synchronous active-high clear of all state
//   readnum, writenum   - register-file selects
//   write               - register-file write enable
//   vsel                - write-back source: 1 = sximm8, 0 = C
//   sximm8              - sign-extended immediate
//   loada, loadb, loadc - operand / result register enables
//   loads               - status register enable
//   asel                - 1 forces the ALU A input to zero
//   shift, aluop        - shifter and ALU controls
//   out                 - register C
//   N, V, Z             - status flags
module cpu_datapath
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_SEL_W-1:0] readnum,
  input  logic [REG_SEL_W-1:0] writenum,
  input  logic                 write,
  input  logic                 vsel,
  input  logic [DATA_W-1:0]    sximm8,
  input  logic                 loada,
  input  logic                 loadb,
  input  logic                 loadc,
  input  logic                 loads,
  input  logic                 asel,
  input  shift_e               shift,
  input  alu_op_e              aluop,
  output logic [DATA_W-1:0]    out,
  output logic                 N,
  output logic                 V,
  output logic                 Z
);

  logic [DATA_W-1:0] rf_wdata, rf_rdata;
  logic [DATA_W-1:0] a_reg, b_reg;
  logic signed [DATA_W-1:0] ain, bin, alu_res;
  logic alu_ovf;

  function automatic logic [DATA_W-1:0] shift_f(input logic [DATA_W-1:0] x,
                                                input shift_e sh);
    case (sh)
      SH_LSL:  return {x[DATA_W-2:0], 1'b0};
      SH_LSR:  return {1'b0, x[DATA_W-1:1]};
      SH_ASR:  return {x[DATA_W-1], x[DATA_W-1:1]};
      default: return x;
    endcase
  endfunction

  // Returns {overflow, result}; overflow is only meaningful for add/sub.
  function automatic logic [DATA_W:0] alu_f(input logic signed [DATA_W-1:0] a,
                                            input logic signed [DATA_W-1:0] b,
                                            input alu_op_e op);
    logic signed [DATA_W-1:0] r;
    logic v;
    v = 1'b0;
    case (op)
      ALU_ADD: begin
        r = a + b;
        v = (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        r = a - b;
        v = (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_AND: r = a & b;
      default: r = ~b;
    endcase
    return {v, r};
  endfunction

  assign rf_wdata = vsel ? sximm8 : out;

  cpu_regfile REGFILE (
    .clk      (clk),
    .reset    (reset),
    .write    (write),
    .writenum (writenum),
    .readnum  (readnum),
    .data_in  (rf_wdata),
    .data_out (rf_rdata)
  );

  assign ain = asel ? '0 : $signed(a_reg);
  assign bin = $signed(shift_f(b_reg, shift));
  assign {alu_ovf, alu_res} = alu_f(ain, bin, aluop);

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg <= '0;
      b_reg <= '0;
      out   <= '0;
      N     <= 1'b0;
      V     <= 1'b0;
      Z     <= 1'b0;
    end else begin
      if (loada) a_reg <= rf_rdata;
      if (loadb) b_reg <= rf_rdata;
      if (loadc) out   <= alu_res;
      if (loads) begin
        N <= alu_res[DATA_W-1];
        V <= alu_ovf;
        Z <= (alu_res == '0);
      end
    end
  end

endmodule

// File: rtl/cpu_regfile.sv
// 8 x 16 register file with one write port and one combinational read port.
// Ports:
//   clk, reset        - clock, synchronous active-high clear of R0-R7
//   write             - write enable
//   writenum, readnum - 3-bit register selects
//   data_in           - write data
//   data_out          - read data for readnum
module cpu_regfile
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write,
  input  logic [REG_SEL_W-1:0] writenum,
  input  logic [REG_SEL_W-1:0] readnum,
  input  logic [DATA_W-1:0]    data_in,
  output logic [DATA_W-1:0]    data_out
);

  logic [DATA_W-1:0] R0, R1, R2, R3, R4, R5, R6, R7;

  // Reset has priority so an instruction aborted by reset never commits.
  always_ff @(posedge clk) begin
    if (reset) begin
      R0 <= '0; R1 <= '0; R2 <= '0; R3 <= '0;
      R4 <= '0; R5 <= '0; R6 <= '0; R7 <= '0;
    end else if (write) begin
      case (writenum)
        3'd0: R0 <= data_in;
        3'd1: R1 <= data_in;
        3'd2: R2 <= data_in;
        3'd3: R3 <= data_in;
        3'd4: R4 <= data_in;
        3'd5: R5 <= data_in;
        3'd6: R6 <= data_in;
        default: R7 <= data_in;
      endcase
    end
  end

  always_comb begin
    data_out = R0;
    case (readnum)
      3'd0: data_out = R0;
      3'd1: data_out = R1;
      3'd2: data_out = R2;
      3'd3: data_out = R3;
      3'd4: data_out = R4;
      3'd5: data_out = R5;
      3'd6: data_out = R6;
      default: data_out = R7;
    endcase
  end

endmodule

// File: rtl/cpu.sv
// Multi-cycle 16-bit processor core: instruction register, decoder and
// control FSM driving the datapath. One instruction executes per start.
// Ports:
//   clk     - rising-edge clock
//   reset   - synchronous active-high reset
//   s       - start, sampled in Wait
//   load    - instruction register load enable
//   in      - instruction word
//   out     - datapath result register C
//   N, V, Z - status flags
//   w       - high while the FSM is in Wait
module cpu
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              s,
  input  logic              load,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out,
  output logic              N,
  output logic              V,
  output logic              Z,
  output logic              w
);

  logic [DATA_W-1:0] ir;
  state_e state, state_nxt;

  logic [2:0]           opcode;
  logic [1:0]           op;
  logic [REG_SEL_W-1:0] rn, rd, rm;
  shift_e               sh;

  logic [REG_SEL_W-1:0] readnum, writenum;
  logic write, vsel, loada, loadb, loadc, loads, asel;
  alu_op_e aluop;
  logic is_mov, is_alu;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = shift_e'(ir[4:3]);
  assign rm     = ir[2:0];
  assign is_mov = (opcode == OPC_MOV);
  assign is_alu = (opcode == OPC_ALU);

  // IR loads whenever asked, regardless of FSM state, so a load together
  // with start is decoded on the following cycle.
  always_ff @(posedge clk) begin
    if (reset) ir <= '0;
    else if (load) ir <= in;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_WAIT;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    readnum   = rn;
    writenum  = rd;
    write     = 1'b0;
    vsel      = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    aluop     = ALU_ADD;
    case (state)
      S_WAIT: if (s) state_nxt = S_DECODE;
      S_DECODE: begin
        if (is_mov && op == OP_MOV_IMM) state_nxt = S_WRITE_IMM;
        else if (is_mov && op == OP_MOV_REG) state_nxt = S_GET_B;
        else if (is_alu && op == OP_MVN) state_nxt = S_GET_B;
        else if (is_alu) state_nxt = S_GET_A;
        else state_nxt = S_WAIT;
      end
      S_WRITE_IMM: begin
        writenum  = rn;
        vsel      = 1'b1;
        write     = 1'b1;
        state_nxt = S_WAIT;
      end
      S_GET_A: begin
        readnum   = rn;
        loada     = 1'b1;
        state_nxt = S_GET_B;
      end
      S_GET_B: begin
        readnum   = rm;
        loadb     = 1'b1;
        state_nxt = S_COMPUTE;
      end
      S_COMPUTE: begin
        loadc = 1'b1;
        // MOV reg is an add of zero and the shifted B operand.
        asel  = is_mov || (op == OP_MVN);
        if (is_alu) begin
          case (op)
            OP_ADD:  aluop = ALU_ADD;
            OP_CMP:  aluop = ALU_SUB;
            OP_AND:  aluop = ALU_AND;
            default: aluop = ALU_NOT;
          endcase
        end
        if (is_alu && op == OP_CMP) begin
          loads     = 1'b1;
          state_nxt = S_WAIT;
        end else begin
          state_nxt = S_WRITE_REG;
        end
      end
      S_WRITE_REG: begin
        writenum  = rd;
        write     = 1'b1;
        state_nxt = S_WAIT;
      end
      default: state_nxt = S_WAIT;
    endcase
  end

  assign w = (state == S_WAIT);

  cpu_datapath DP (
    .clk      (clk),
    .reset    (reset),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .vsel     (vsel),
    .sximm8   (sx_imm8(ir[7:0])),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .shift    (sh),
    .aluop    (aluop),
    .out      (out),
    .N        (N),
    .V        (V),
    .Z        (Z)
  );

endmodule

// File: tb/tb_cpu.sv
// Directed testbench for cpu: runs hand-encoded instructions and compares
// register file, result, flags and start-to-idle edge counts against
// hand-computed values.
module tb_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        s = 1'b0;
  logic        load = 1'b0;
  logic [15:0] in = '0;
  logic [15:0] out;
  logic        N, V, Z, w;

  int n_checks = 0;
  int n_fail = 0;

  cpu DUT (
    .clk   (clk),
    .reset (reset),
    .s     (s),
    .load  (load),
    .in    (in),
    .out   (out),
    .N     (N),
    .V     (V),
    .Z     (Z),
    .w     (w)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Load and start on the same edge, then count edges until w returns high.
  task automatic exec(input logic [15:0] instr, output int edges);
    @(negedge clk);
    in = instr; load = 1'b1; s = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    load = 1'b0; s = 1'b0;
    check("w_fall", {31'b0, w}, 32'd0);
    while (w !== 1'b1 && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (edges >= 20) check("w_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input string tag, input logic [15:0] instr, input int exp_edges);
    int e;
    exec(instr, e);
    check(tag, e, exp_edges);
  endtask

  initial begin
    int e;
    // Reset
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_w", {31'b0, w}, 32'd1);
    check("rst_out", {16'b0, out}, 32'd0);
    check("rst_nvz", {29'b0, N, V, Z}, 32'd0);
    check("rst_R0", {16'b0, DUT.DP.REGFILE.R0}, 32'd0);
    check("rst_R7", {16'b0, DUT.DP.REGFILE.R7}, 32'd0);

    // MOV R0,#7
    run("movimm_edges", 16'hD007, 3);
    check("R0_7", {16'b0, DUT.DP.REGFILE.R0}, 32'd7);

    // Sign extension and LSR
    run("movneg_edges", 16'hD1FE, 3);
    check("R1_sx", {16'b0, DUT.DP.REGFILE.R1}, 32'hFFFE);
    run("movlsr_edges", 16'hC051, 5);
    check("R2_lsr", {16'b0, DUT.DP.REGFILE.R2}, 32'h7FFF);
    check("out_lsr", {16'b0, out}, 32'h7FFF);

    // ADD R4,R1,R3,LSL : 2 + (3<<1) = 8
    run("mov_r1", 16'hD102, 3);
    run("mov_r3", 16'hD303, 3);
    run("add_edges", 16'hA18B, 6);
    check("R4_add", {16'b0, DUT.DP.REGFILE.R4}, 32'd8);
    check("out_add", {16'b0, out}, 32'd8);
    check("add_nvz", {29'b0, N, V, Z}, 32'd0);

    // CMP R5,R5
    run("mov_r5", 16'hD503, 3);
    run("cmp_edges", 16'hAD05, 5);
    check("cmp_eq_nvz", {29'b0, N, V, Z}, 32'b001);
    check("cmp_R5", {16'b0, DUT.DP.REGFILE.R5}, 32'd3);
    check("cmp_R4", {16'b0, DUT.DP.REGFILE.R4}, 32'd8);

    // Build 0x8000 in R6 by shifting 0xFF80 left eight times
    run("mov_r6", 16'hD680, 3);
    for (int i = 0; i < 8; i++) exec(16'hC0CE, e);
    check("R6_8000", {16'b0, DUT.DP.REGFILE.R6}, 32'h8000);
    run("mov_r7", 16'hD701, 3);
    run("cmp_ovf_edges", 16'hAE07, 5);
    check("cmp_ovf_nvz", {29'b0, N, V, Z}, 32'b010);
    check("cmp_ovf_out", {16'b0, out}, 32'h7FFF);

    // AND, MVN, ASR
    run("mov_r1_6", 16'hD106, 3);
    run("and_edges", 16'hB103, 6);
    check("R0_and", {16'b0, DUT.DP.REGFILE.R0}, 32'd2);
    run("mvn_edges", 16'hB843, 5);
    check("R2_mvn", {16'b0, DUT.DP.REGFILE.R2}, 32'hFFFC);
    exec(16'hC09E, e);
    check("R4_asr", {16'b0, DUT.DP.REGFILE.R4}, 32'hC000);
    check("asr_flags_kept", {29'b0, N, V, Z}, 32'b010);

    // Illegal opcode returns to Wait after Decode
    run("illegal_edges", 16'h0000, 2);
    check("illegal_R4", {16'b0, DUT.DP.REGFILE.R4}, 32'hC000);

    // Reset during GetB of ADD R4,R1,R3,LSL
    @(negedge clk);
    in = 16'hA18B; load = 1'b1; s = 1'b1;
    @(posedge clk);            // -> Decode
    @(negedge clk); load = 1'b0; s = 1'b0;
    @(posedge clk);            // -> GetA
    @(posedge clk);            // -> GetB
    @(negedge clk);
    check("abort_w_busy", {31'b0, w}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_w", {31'b0, w}, 32'd1);
    check("abort_R4", {16'b0, DUT.DP.REGFILE.R4}, 32'd0);
    check("abort_out", {16'b0, out}, 32'd0);
    repeat (3) @(negedge clk);
    check("abort_idle_w", {31'b0, w}, 32'd1);
    check("abort_idle_R4", {16'b0, DUT.DP.REGFILE.R4}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
